// File: rtl/seg7_scan_controller.sv
// Time-multiplexed 8-digit hex display driver with frame-synchronous shadow loading.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero nibble.
module seg7_scan_controller #(
    parameter int DIGIT_PERIOD = 100000,
    parameter int BLANK_CYCLES = 4,
    parameter int NUM_DIGITS   = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] value,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  enable_mask,
    input  logic        load_req,
    output logic        load_ack,
    output logic [7:0]  segments,
    output logic [7:0]  digitselect,
    output logic        frame_tick
);

    localparam int              PW         = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(DIGIT_PERIOD - 1);
    localparam logic [PW-1:0]   BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [2:0]      IDX_LAST   = 3'(NUM_DIGITS - 1);

    typedef enum logic {
        Idle,
        Pending
    } loadState_t;

    loadState_t loadState_q, loadState_d;

    logic [PW-1:0] prescCount_q, prescCount_d;
    logic [2:0]    digitIdx_q, digitIdx_d;
    logic [31:0]   pendValue_q, pendValue_d;
    logic [7:0]    pendDp_q, pendDp_d;
    logic [31:0]   shadowValue_q, shadowValue_d;
    logic [7:0]    shadowDp_q, shadowDp_d;
    logic          loadAck_q, loadAck_d;
    logic          frameTick_q, frameTick_d;
    logic [7:0]    segments_q, segments_d;
    logic [7:0]    digitSel_q, digitSel_d;

    logic       slotEnd;
    logic       frameWrap;
    logic       slotValid;
    logic       digitBlank;
    logic [3:0] curNibble;

    function automatic logic [6:0] hexToSeg(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = 7'h40;
            4'h1:    pattern = 7'h79;
            4'h2:    pattern = 7'h24;
            4'h3:    pattern = 7'h30;
            4'h4:    pattern = 7'h19;
            4'h5:    pattern = 7'h12;
            4'h6:    pattern = 7'h02;
            4'h7:    pattern = 7'h78;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h10;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h03;
            4'hC:    pattern = 7'h46;
            4'hD:    pattern = 7'h21;
            4'hE:    pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

    always_comb begin
        slotEnd      = (prescCount_q == PRESC_LAST);
        frameWrap    = slotEnd && (digitIdx_q == IDX_LAST);
        prescCount_d = slotEnd ? '0 : prescCount_q + PW'(1);
        digitIdx_d   = digitIdx_q;
        if (slotEnd) begin
            digitIdx_d = frameWrap ? 3'd0 : digitIdx_q + 3'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            loadState_q <= Idle;
        end else begin
            loadState_q <= loadState_d;
        end
    end

    always_comb begin
        loadState_d = loadState_q;
        case (loadState_q)
            Idle:    if (load_req)  loadState_d = Pending;
            Pending: if (frameWrap) loadState_d = Idle;
            default: loadState_d = Idle;
        endcase
    end

    // A request still high on the boundary cycle itself is the latest value and wins over pending.
    always_comb begin
        pendValue_d   = pendValue_q;
        pendDp_d      = pendDp_q;
        shadowValue_d = shadowValue_q;
        shadowDp_d    = shadowDp_q;
        loadAck_d     = 1'b0;
        if (load_req) begin
            pendValue_d = value;
            pendDp_d    = dp_in;
        end
        if (loadState_q == Pending && frameWrap) begin
            shadowValue_d = load_req ? value : pendValue_q;
            shadowDp_d    = load_req ? dp_in : pendDp_q;
            loadAck_d     = 1'b1;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [7:0] shadowBlank_q, shadowBlank_d;

    function automatic logic [7:0] leadingBlank(input logic [31:0] v);
        logic [7:0] flags;
        logic       allZero;
        flags   = '0;
        allZero = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            if (k < NUM_DIGITS) begin
                allZero  = allZero && (v[4*k +: 4] == 4'h0);
                flags[k] = allZero;
            end
        end
        return flags;
    endfunction

    always_comb begin
        shadowBlank_d = shadowBlank_q;
        if (loadAck_d) begin
            shadowBlank_d = leadingBlank(shadowValue_d);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadowBlank_q <= leadingBlank(32'h0);
        end else begin
            shadowBlank_q <= shadowBlank_d;
        end
    end

    assign digitBlank = shadowBlank_q[digitIdx_q];
`else
    assign digitBlank = 1'b0;
`endif

    // Pin values are decoded from the current slot state and registered, so they lag it by one cycle.
    always_comb begin
        slotValid   = (32'(digitIdx_q) < NUM_DIGITS);
        curNibble   = shadowValue_q[{digitIdx_q, 2'b00} +: 4];
        segments_d  = {~shadowDp_q[digitIdx_q], digitBlank ? 7'h7F : hexToSeg(curNibble)};
        digitSel_d  = 8'hFF;
        if (prescCount_q >= BLANK_END && enable_mask[digitIdx_q] && slotValid) begin
            digitSel_d = ~(8'b1 << digitIdx_q);
        end
        frameTick_d = frameWrap;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescCount_q  <= '0;
            digitIdx_q    <= 3'd0;
            pendValue_q   <= 32'h0;
            pendDp_q      <= 8'h0;
            shadowValue_q <= 32'h0;
            shadowDp_q    <= 8'h0;
            loadAck_q     <= 1'b0;
            frameTick_q   <= 1'b0;
            segments_q    <= 8'hFF;
            digitSel_q    <= 8'hFF;
        end else begin
            prescCount_q  <= prescCount_d;
            digitIdx_q    <= digitIdx_d;
            pendValue_q   <= pendValue_d;
            pendDp_q      <= pendDp_d;
            shadowValue_q <= shadowValue_d;
            shadowDp_q    <= shadowDp_d;
            loadAck_q     <= loadAck_d;
            frameTick_q   <= frameTick_d;
            segments_q    <= segments_d;
            digitSel_q    <= digitSel_d;
        end
    end

    assign load_ack    = loadAck_q;
    assign frame_tick  = frameTick_q;
    assign segments    = segments_q;
    assign digitselect = digitSel_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Randomized and directed bench for seg7_scan_controller against a cycle-count based display model.
// Honours SEG7_LEADING_ZERO_BLANK_EN in the model when the macro is defined.
module tb_seg7_scan_controller;

    localparam int DP  = 8;
    localparam int BC  = 2;
    localparam int ND  = 8;
    localparam int FRAME = DP * ND;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] value;
    logic [7:0]  dp_in;
    logic [7:0]  enable_mask;
    logic        load_req;
    logic        load_ack;
    logic [7:0]  segments;
    logic [7:0]  digitselect;
    logic        frame_tick;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference state: edges since reset release plus the values the display should hold.
    int          edgeCount;
    logic [31:0] shadowV;
    logic [7:0]  shadowDp;
    logic [31:0] pendV;
    logic [7:0]  pendDp;
    bit          pendFlag;

    logic [7:0] segTable [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg7_scan_controller #(
        .DIGIT_PERIOD(DP),
        .BLANK_CYCLES(BC),
        .NUM_DIGITS  (ND)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .value      (value),
        .dp_in      (dp_in),
        .enable_mask(enable_mask),
        .load_req   (load_req),
        .load_ack   (load_ack),
        .segments   (segments),
        .digitselect(digitselect),
        .frame_tick (frame_tick)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", tag, edgeCount, observed, expected);
        end
    endtask

    function automatic logic [7:0] modelSegments(input int slot);
        int   nib;
        int   msd;
        logic [7:0] pattern;
        bit   blanked;
        nib     = int'((shadowV >> (4 * slot)) & 32'hF);
        pattern = segTable[nib];
        blanked = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        msd = 0;
        for (int d = 0; d < ND; d++) begin
            if (((shadowV >> (4 * d)) & 32'hF) != 0) msd = d;
        end
        blanked = (slot > msd);
`else
        msd = 0;
`endif
        return {~shadowDp[slot], blanked ? 7'h7F : pattern[6:0]};
    endfunction

    // One clock: drive inputs, predict the pins after the coming edge, advance the model, compare.
    task automatic applyStimulus(input logic req, input logic [31:0] v, input logic [7:0] dp,
                                 input logic [7:0] mask);
        int         k;
        int         slot;
        int         phase;
        logic [7:0] expDs;
        logic [7:0] expSeg;
        logic       expTick;
        logic       expAck;
        load_req    = req;
        value       = v;
        dp_in       = dp;
        enable_mask = mask;
        k       = edgeCount % FRAME;
        slot    = k / DP;
        phase   = k % DP;
        expDs   = (phase >= BC && mask[slot]) ? ~(8'b1 << slot) : 8'hFF;
        expSeg  = modelSegments(slot);
        expTick = (k == FRAME - 1);
        expAck  = 1'b0;
        if (expTick && pendFlag) begin
            shadowV  = req ? v : pendV;
            shadowDp = req ? dp : pendDp;
            pendFlag = 1'b0;
            expAck   = 1'b1;
        end else if (req) begin
            pendV    = v;
            pendDp   = dp;
            pendFlag = 1'b1;
        end
        @(posedge clock);
        edgeCount++;
        #1;
        checkOutput("digitselect", {24'h0, digitselect}, {24'h0, expDs});
        checkOutput("segments", {24'h0, segments}, {24'h0, expSeg});
        checkOutput("frame_tick", {31'h0, frame_tick}, {31'h0, expTick});
        checkOutput("load_ack", {31'h0, load_ack}, {31'h0, expAck});
    endtask

    task automatic idleUntil(input int framePos, input logic [7:0] mask);
        while ((edgeCount % FRAME) != framePos) applyStimulus(1'b0, 32'h0, 8'h0, mask);
    endtask

    task automatic checkBlankPins(input string tag);
        checkOutput({tag, "_digitselect"}, {24'h0, digitselect}, 32'hFF);
        checkOutput({tag, "_segments"}, {24'h0, segments}, 32'hFF);
        checkOutput({tag, "_load_ack"}, {31'h0, load_ack}, 32'h0);
        checkOutput({tag, "_frame_tick"}, {31'h0, frame_tick}, 32'h0);
    endtask

    task automatic resetModel();
        edgeCount = 0;
        shadowV   = 32'h0;
        shadowDp  = 8'h0;
        pendV     = 32'h0;
        pendDp    = 8'h0;
        pendFlag  = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        value       = 32'h0;
        dp_in       = 8'h0;
        enable_mask = 8'hFF;
        load_req    = 1'b0;
        resetModel();
        #12;
        checkBlankPins("reset");
        #6 reset_n = 1'b1;

        // Plain scan with zero shadow value.
        repeat (FRAME + 2) applyStimulus(1'b0, 32'h0, 8'h0, 8'hFF);

        // Held request issued in slot 3, released once acked.
        idleUntil(3 * DP, 8'hFF);
        do applyStimulus(1'b1, 32'h0000_00F8, 8'h01, 8'hFF); while ((edgeCount % FRAME) != 0);
        repeat (FRAME) applyStimulus(1'b0, 32'h0, 8'h0, 8'hFF);

        // Two short requests within one frame: latest wins, one ack.
        idleUntil(DP, 8'hFF);
        applyStimulus(1'b1, 32'h1111_1111, 8'h00, 8'hFF);
        repeat (5) applyStimulus(1'b0, 32'h0, 8'h0, 8'hFF);
        applyStimulus(1'b1, 32'h2222_2222, 8'h00, 8'hFF);
        idleUntil(0, 8'hFF);
        repeat (FRAME) applyStimulus(1'b0, 32'h0, 8'h0, 8'hFF);

        // Upper four digits masked off.
        repeat (FRAME) applyStimulus(1'b0, 32'h0, 8'h0, 8'h0F);

        // Value with leading zeros.
        applyStimulus(1'b1, 32'h0000_0A05, 8'h00, 8'hFF);
        idleUntil(0, 8'hFF);
        repeat (FRAME) applyStimulus(1'b0, 32'h0, 8'h0, 8'hFF);

        // Random requests, values, decimal points and masks.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(15) == 0), $urandom, 8'($urandom), 8'($urandom));
        end
        repeat (FRAME) applyStimulus(1'b0, 32'h0, 8'h0, 8'hFF);

        // Reset arriving while a request is pending in slot 5.
        idleUntil(2 * DP, 8'hFF);
        applyStimulus(1'b1, 32'h8765_4321, 8'hAA, 8'hFF);
        idleUntil(5 * DP + 3, 8'hFF);
        #2 reset_n = 1'b0;
        load_req = 1'b0;
        #1;
        checkBlankPins("midreset");
        repeat (3) begin
            @(posedge clock);
            #1;
            checkBlankPins("inreset");
        end
        #2 reset_n = 1'b1;
        resetModel();
        repeat (2 * FRAME + 3) applyStimulus(1'b0, 32'h0, 8'h0, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
- Time-multiplexes up to 8 hex digits onto the shared 8-digit 7-segment display. The display has common segment lines and per-digit active-low anodes.
- Holds a 32-bit display value in a shadow register, with a request/acknowledge load interface. New values are applied only at frame boundaries, so the display never tears.
- Sits between the counter/datapath logic and the board's segments/digitselect pins. Replaces the fixed single-digit hookup.

Parameters:
- DIGIT_PERIOD, 100000: clock cycles each digit slot lasts (1 ms at 100 MHz). Must be >= 4.
- BLANK_CYCLES, 4: cycles at the start of each slot during which all anodes are off (anti-ghosting). Must be < DIGIT_PERIOD.
- NUM_DIGITS, 8: digits scanned, range 1..8. Slots run 0..NUM_DIGITS-1.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous reset, active-low
- value  input  32  nibble k drives digit k (digit 0 = rightmost)
- dp_in  input  8  decimal point per digit, 1 = lit
- enable_mask  input  8  1 = digit may be lit; sampled live each cycle
- load_req  input  1  request to load value/dp_in into the display
- load_ack  output  1  one-cycle pulse: the request was applied to the display
- segments  output  8  active-low; [0]=a … [6]=g, [7]=dp
- digitselect  output  8  active-low one-hot anode select
- frame_tick  output  1  one-cycle pulse when the digit index wraps to 0

Behaviour:
- Reset (async assert, sync release):
  - Prescaler = 0, digit index = 0.
  - Shadow value = 0, shadow dp = 0, pending = 0.
  - digitselect = 8'hFF, segments = 8'hFF, load_ack = 0, frame_tick = 0.
- Prescaler:
  - Counts 0..DIGIT_PERIOD-1, then wraps to 0.
  - On wrap, the digit index increments. Index NUM_DIGITS-1 wraps to 0.
  - frame_tick is asserted in the same cycle the index becomes 0.
- Anodes:
  - Low only for the current index.
  - Only while prescaler >= BLANK_CYCLES.
  - Only if enable_mask[index] = 1 and index < NUM_DIGITS.
  - Otherwise 8'hFF. A masked slot still consumes its full period.
- Segments decode shadow nibble[index] to the standard hex patterns (active-low, bit 7 = dp off):
  - 0 = 0xC0, 1 = 0xF9, 8 = 0x80, F = 0x8E.
  - Bit 7 = ~shadow_dp[index].
- All outputs are registered: one-cycle latency from prescaler/index state to the pins.
- Load state machine:
  - IDLE: when load_req = 1, capture value/dp_in into the pending register and go to PENDING.
  - PENDING: while load_req = 1, pending is re-captured every cycle (latest value wins).
  - PENDING: on the frame-boundary cycle, pending is copied to the shadow registers, load_ack pulses for one cycle coincident with frame_tick, and the state returns to IDLE.
  - If load_req is still high in the cycle after load_ack, it is treated as a new request.
  - If load_req drops before the boundary, the last captured value is still applied and acked.
  - Shadow values are first displayed in slot 0 of the new frame.
- Reset mid-frame or mid-request: the pending request is discarded, no ack is issued, and the display blanks immediately.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits above the most-significant nonzero nibble (within NUM_DIGITS) show segments[6:0] = 7'h7F (blank).
  - dp is still honoured on blanked digits.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Blank flags are computed from the shadow value when it is loaded.
- Undefined: every enabled digit shows its nibble, including leading zeros.

Test Plan (DIGIT_PERIOD=8, BLANK_CYCLES=2, NUM_DIGITS=8):
1. Reset, then run 64 cycles:
   - digitselect cycles FE, FD, … 7F, each low for 6 of 8 cycles, FF for the first 2.
   - segments = C0 throughout.
   - frame_tick pulses every 64 cycles.
2. load_req held high with value=32'h0000_00F8, dp_in=8'h01, issued at slot 3:
   - load_ack arrives coincident with the next frame_tick.
   - Slot 0 then shows 0x00 (8 with dp); slot 1 shows 0x8E.
3. load_req high for one cycle with 32'h1111_1111, then 32'h2222_2222 on a second pulse, both within the same frame:
   - A single ack.
   - Display shows all 2s (0xA4).
4. enable_mask=8'h0F:
   - digitselect stays FF during slots 4-7.
   - Frame length is still 64 cycles.
5. Assert reset_n low during PENDING at slot 5:
   - Outputs are FF/FF immediately, with no load_ack.
   - After release, the index restarts at 0 and the display shows the old value 0.
6. With SEG7_LEADING_ZERO_BLANK_EN and value=32'h0000_0A05:
   - Slots 0-2 show 0x92, 0xC0, 0x88.
   - Slots 3-7 show segments 0xFF while their anodes are still driven.
